ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for a 1W/1R RAM wrapper: write and read ports
// are each round-robin arbitrated. Optional RAM_ARB_RD_FORWARD_EN.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_m, we_m         : per-master request / write(1) or read(0)
//   addr_m0/1, wdata_m0/1 : per-master address and write data
//   gnt_m               : combinational grant (consumed at posedge)
//   rd_valid_m, rd_data : read return, one cycle after read grant
//   mem_*               : RAM wrapper strobes, addresses, data
//   mem_enable_out/mem_data_out : RAM wrapper read return
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_m,
  input  logic [1:0]            we_m,
  input  logic [ADDR_WIDTH-1:0] addr_m0,
  input  logic [ADDR_WIDTH-1:0] addr_m1,
  input  logic [DATA_WIDTH-1:0] wdata_m0,
  input  logic [DATA_WIDTH-1:0] wdata_m1,
  output logic [1:0]            gnt_m,
  output logic [1:0]            rd_valid_m,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_enable_out,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  logic [1:0] wr_cand;
  logic [1:0] rd_cand;
  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;
  logic       wr_win;
  logic       rd_win;
  logic       wr_pri;
  logic       rd_pri;
  logic       rd_tag;

  // Last issued values, held while the port is idle
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  always_comb begin
    wr_cand = req_m & we_m;
    rd_cand = req_m & ~we_m;
    wr_gnt  = 2'b00;
    rd_gnt  = 2'b00;
    case (wr_cand)
      2'b01:   wr_gnt = 2'b01;
      2'b10:   wr_gnt = 2'b10;
      2'b11:   wr_gnt = wr_pri ? 2'b10 : 2'b01;
      default: wr_gnt = 2'b00;
    endcase
    case (rd_cand)
      2'b01:   rd_gnt = 2'b01;
      2'b10:   rd_gnt = 2'b10;
      2'b11:   rd_gnt = rd_pri ? 2'b10 : 2'b01;
      default: rd_gnt = 2'b00;
    endcase
    if (reset) begin
      wr_gnt = 2'b00;
      rd_gnt = 2'b00;
    end
  end

  assign wr_win = wr_gnt[1];
  assign rd_win = rd_gnt[1];
  assign gnt_m  = wr_gnt | rd_gnt;

  assign mem_write_enable = |wr_gnt;
  assign mem_read_enable  = |rd_gnt;

  always_comb begin
    mem_write_address = wr_addr_q;
    mem_data_in       = wr_data_q;
    mem_read_address  = rd_addr_q;
    if (mem_write_enable) begin
      mem_write_address = wr_win ? addr_m1 : addr_m0;
      mem_data_in       = wr_win ? wdata_m1 : wdata_m0;
    end
    if (mem_read_enable) begin
      mem_read_address = rd_win ? addr_m1 : addr_m0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pri    <= 1'b0;
      rd_pri    <= 1'b0;
      rd_tag    <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (mem_write_enable) begin
        wr_pri    <= ~wr_win;
        wr_addr_q <= mem_write_address;
        wr_data_q <= mem_data_in;
      end
      if (mem_read_enable) begin
        rd_pri    <= ~rd_win;
        rd_tag    <= rd_win;
        rd_addr_q <= mem_read_address;
      end
    end
  end

  // Reset masks a read return that was in flight
  always_comb begin
    rd_valid_m = 2'b00;
    if (!reset && mem_enable_out) begin
      rd_valid_m = rd_tag ? 2'b10 : 2'b01;
    end
  end

`ifdef RAM_ARB_RD_FORWARD_EN
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  // Same-cycle write/read to one address: return the new data
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= mem_write_enable && mem_read_enable &&
                  (mem_write_address == mem_read_address);
      fwd_data <= mem_data_in;
    end
  end

  assign rd_data = fwd_hit ? fwd_data : mem_data_out;
`else
  assign rd_data = mem_data_out;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM wrapper
// and a queue of expected read returns.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_m = 2'b00;
  logic [1:0] we_m = 2'b00;
  logic [7:0] addr_m0 = '0;
  logic [7:0] addr_m1 = '0;
  logic [7:0] wdata_m0 = '0;
  logic [7:0] wdata_m1 = '0;
  logic [1:0] gnt_m;
  logic [1:0] rd_valid_m;
  logic [7:0] rd_data;
  logic       mem_write_enable;
  logic       mem_read_enable;
  logic [7:0] mem_write_address;
  logic [7:0] mem_read_address;
  logic [7:0] mem_data_in;
  logic       mem_enable_out = 1'b0;
  logic [7:0] mem_data_out = '0;

  int passed = 0;
  int total = 0;

  typedef struct {
    logic [1:0] v;
    logic [7:0] d;
  } rd_exp_t;

  rd_exp_t    sb[$];
  logic [7:0] ram [256];
  logic [7:0] shadow [256];

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .req_m(req_m),
    .we_m(we_m),
    .addr_m0(addr_m0),
    .addr_m1(addr_m1),
    .wdata_m0(wdata_m0),
    .wdata_m1(wdata_m1),
    .gnt_m(gnt_m),
    .rd_valid_m(rd_valid_m),
    .rd_data(rd_data),
    .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable),
    .mem_write_address(mem_write_address),
    .mem_read_address(mem_read_address),
    .mem_data_in(mem_data_in),
    .mem_enable_out(mem_enable_out),
    .mem_data_out(mem_data_out)
  );

  // RAM wrapper: read-before-write, one cycle read latency
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_write_address] <= mem_data_in;
    if (mem_read_enable) mem_data_out <= ram[mem_read_address];
    mem_enable_out <= mem_read_enable;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic [1:0] req,
                      input logic [1:0] we,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] eg);
    rd_exp_t    e;
    rd_exp_t    n;
    logic [1:0] wr;
    logic [1:0] rd;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    @(negedge clk);
    reset = r; req_m = req; we_m = we;
    addr_m0 = a0; addr_m1 = a1; wdata_m0 = d0; wdata_m1 = d1;
    #1;
    e.v = 2'b00; e.d = '0;
    if (sb.size() > 0) e = sb.pop_front();
    if (r) e.v = 2'b00;
    check("gnt_m", {30'd0, gnt_m}, {30'd0, eg});
    check("rd_valid_m", {30'd0, rd_valid_m}, {30'd0, e.v});
    if (e.v != 2'b00) check("rd_data", {24'd0, rd_data}, {24'd0, e.d});
    wr = eg & req & we;
    rd = eg & req & ~we;
    wa = wr[1] ? a1 : a0;
    wd = wr[1] ? d1 : d0;
    ra = rd[1] ? a1 : a0;
    check("mem_we", {31'd0, mem_write_enable}, {31'd0, |wr});
    check("mem_re", {31'd0, mem_read_enable}, {31'd0, |rd});
    if (wr != 2'b00) begin
      check("mem_waddr", {24'd0, mem_write_address}, {24'd0, wa});
      check("mem_din", {24'd0, mem_data_in}, {24'd0, wd});
    end
    if (rd != 2'b00) check("mem_raddr", {24'd0, mem_read_address}, {24'd0, ra});
    n.v = rd;
    n.d = shadow[ra];
`ifdef RAM_ARB_RD_FORWARD_EN
    if (wr != 2'b00 && rd != 2'b00 && wa == ra) n.d = wd;
`endif
    sb.push_back(n);
    if (wr != 2'b00) shadow[wa] = wd;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    // Reset: requests present but nothing granted
    step(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    step(1'b1, 2'b11, 2'b01, 8'h05, 8'h06, 8'h77, 8'h00, 2'b00);
    // m0 write 0x10=A5, then m1 reads it back
    step(1'b0, 2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01);
    step(1'b0, 2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00, 2'b10);
    idle();
    check("hold_waddr", {24'd0, mem_write_address}, 32'h10);
    check("hold_din", {24'd0, mem_data_in}, 32'hA5);
    check("hold_raddr", {24'd0, mem_read_address}, 32'h10);
    // Seed 0x01/0x02, then contended reads alternate m0,m1,m0,m1
    step(1'b0, 2'b01, 2'b01, 8'h01, 8'h00, 8'h11, 8'h00, 2'b01);
    step(1'b0, 2'b10, 2'b10, 8'h00, 8'h02, 8'h00, 8'h22, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00,
           (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle();
    // Same-cycle write and read to 0x20
    step(1'b0, 2'b11, 2'b01, 8'h20, 8'h20, 8'h3C, 8'h00, 2'b11);
    idle();
    // Different addresses, then contention reveals the pointers
    step(1'b0, 2'b11, 2'b01, 8'h30, 8'h10, 8'h55, 8'h00, 2'b11);
    step(1'b0, 2'b11, 2'b11, 8'h40, 8'h41, 8'h66, 8'h99, 2'b10);
    step(1'b0, 2'b11, 2'b00, 8'h30, 8'h41, 8'h00, 8'h00, 2'b01);
    idle();
    // Read in flight when reset hits: return is dropped
    step(1'b0, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01);
    step(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    step(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    // First cycles after reset: m0 wins, then m1
    step(1'b0, 2'b11, 2'b00, 8'h20, 8'h01, 8'h00, 8'h00, 2'b01);
    step(1'b0, 2'b10, 2'b00, 8'h00, 8'h01, 8'h00, 8'h00, 2'b10);
    idle();
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
